program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 20 ++
 rtl/program_loader.sv | 153 +++++++++++++++
 tb/tb_program_loader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - instruction ROM write port between loader and ROM
interface program_loader_if #(
    parameter int ROM_ADDRESS_BITWIDTH = 12
);
    logic                            rom_wren;
    logic [ROM_ADDRESS_BITWIDTH-1:0] rom_write_address;
    logic [31:0]                     rom_write_data;

    modport master (
        output rom_wren,
        output rom_write_address,
        output rom_write_data
    );

    modport slave (
        input rom_wren,
        input rom_write_address,
        input rom_write_data
    );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - UART boot loader writing a length-prefixed program into ROM
module program_loader #(
    parameter int CLKS_PER_BIT         = 434,
    parameter int ROM_ADDRESS_BITWIDTH = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              uart_rx,
    program_loader_if.master  rom,
    output logic              cpu_reset_n,
    output logic              loading,
    output logic              error
);
    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]   MAX_WORDS = 32'(1) << (ROM_ADDRESS_BITWIDTH - 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {LD_HEADER, LD_WORDS, LD_RUN, LD_FAULT} ld_state_e;

    rx_state_e rx_state_q, rx_state_d;
    ld_state_e ld_state_q, ld_state_d;

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0] clk_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          tick, byte_valid, frame_err;

    logic [1:0]    byte_cnt_q;
    logic [31:0]   asm_q, count_q, idx_q, new_word;
    logic          wren_q, word_done;
    logic [ROM_ADDRESS_BITWIDTH-1:0] addr_q;
    logic [31:0]   data_q;

    // Receiver: synchronizer, bit timing and shift register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            clk_cnt_q  <= (rx_state_q == RX_IDLE || tick) ? '0 : clk_cnt_q + 1'b1;
            if (rx_state_q == RX_IDLE) begin
                bit_cnt_q <= '0;
            end else if (rx_state_q == RX_DATA && tick) begin
                shift_q   <= {rx_sync_q, shift_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        tick = 1'b0;
        case (rx_state_q)
            RX_START:         tick = (clk_cnt_q == HALF_M1);
            RX_DATA, RX_STOP: tick = (clk_cnt_q == FULL_M1);
            default:          tick = 1'b0;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (!rx_sync_q && rx_prev_q) rx_state_d = RX_START;
            RX_START: if (tick) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (tick) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = (rx_state_q == RX_STOP) && tick && rx_sync_q;
        frame_err  = (rx_state_q == RX_STOP) && tick && !rx_sync_q;
    end

    // Loader: bytes accumulate little-endian by shifting in from the top
    assign word_done = byte_valid && (byte_cnt_q == 2'd3);
    assign new_word  = {shift_q, asm_q[31:8]};

    always_ff @(posedge clk) begin
        if (!reset_n) ld_state_q <= LD_HEADER;
        else          ld_state_q <= ld_state_d;
    end

    always_comb begin
        ld_state_d = ld_state_q;
        case (ld_state_q)
            LD_HEADER: begin
                if (frame_err)                   ld_state_d = LD_FAULT;
                else if (word_done) begin
                    if (new_word == 32'd0)       ld_state_d = LD_RUN;
                    else if (new_word > MAX_WORDS) ld_state_d = LD_FAULT;
                    else                         ld_state_d = LD_WORDS;
                end
            end
            LD_WORDS: begin
                if (frame_err)                          ld_state_d = LD_FAULT;
                else if (wren_q && idx_q == count_q)    ld_state_d = LD_RUN;
            end
            default: ld_state_d = ld_state_q;
        endcase
    end

    always_comb begin
        cpu_reset_n = (ld_state_q == LD_RUN);
        error       = (ld_state_q == LD_FAULT);
        loading     = (ld_state_q == LD_WORDS) ||
                      ((ld_state_q == LD_HEADER) && (byte_cnt_q != 2'd0 || rx_state_q != RX_IDLE));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            byte_cnt_q <= '0;
            asm_q      <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            wren_q <= 1'b0;
            if ((ld_state_q == LD_HEADER || ld_state_q == LD_WORDS) && byte_valid) begin
                asm_q      <= new_word;
                byte_cnt_q <= byte_cnt_q + 1'b1;
            end
            if (ld_state_q == LD_HEADER && word_done) begin
                count_q <= new_word;
                idx_q   <= '0;
            end
            if (ld_state_q == LD_WORDS && word_done) begin
                wren_q <= 1'b1;
                data_q <= new_word;
                addr_q <= {idx_q[ROM_ADDRESS_BITWIDTH-3:0], 2'b00};
                idx_q  <= idx_q + 1'b1;
            end
        end
    end

    assign rom.rom_wren          = wren_q;
    assign rom.rom_write_address = addr_q;
    assign rom.rom_write_data    = data_q;
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;
    localparam int CPB = 8;
    localparam int AW  = 12;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic uart_rx = 1'b1;
    logic cpu_reset_n, loading, error;

    int checks = 0;
    int failures = 0;

    program_loader_if #(.ROM_ADDRESS_BITWIDTH(AW)) rom_if ();

    program_loader #(.CLKS_PER_BIT(CPB), .ROM_ADDRESS_BITWIDTH(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .uart_rx     (uart_rx),
        .rom         (rom_if),
        .cpu_reset_n (cpu_reset_n),
        .loading     (loading),
        .error       (error)
    );

    always #5 clk = ~clk;

    // Write monitor, cleared while reset is held
    int          n_wr = 0;
    int          n_consec = 0;
    int          n_cpu_hi_at_wr = 0;
    logic        prev_wren = 1'b0;
    logic [31:0] wr_addr [8];
    logic [31:0] wr_data [8];

    always @(negedge clk) begin
        if (!reset_n) begin
            n_wr <= 0;
            n_consec <= 0;
            n_cpu_hi_at_wr <= 0;
            prev_wren <= 1'b0;
        end else begin
            prev_wren <= rom_if.rom_wren;
            if (rom_if.rom_wren) begin
                if (n_wr < 8) begin
                    wr_addr[n_wr] <= 32'(rom_if.rom_write_address);
                    wr_data[n_wr] <= rom_if.rom_write_data;
                end
                n_wr <= n_wr + 1;
                if (prev_wren) n_consec <= n_consec + 1;
                if (cpu_reset_n) n_cpu_hi_at_wr <= n_cpu_hi_at_wr + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_wren",    32'(rom_if.rom_wren), 32'd0);
        check("reset_addr",    32'(rom_if.rom_write_address), 32'd0);
        check("reset_data",    rom_if.rom_write_data, 32'd0);
        check("reset_cpu",     32'(cpu_reset_n), 32'd0);
        check("reset_loading", 32'(loading), 32'd0);
        check("reset_error",   32'(error), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // 3-cycle glitch in idle must not start a byte
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (5 * CPB) @(negedge clk);
        check("glitch_loading", 32'(loading), 32'd0);
        check("glitch_error",   32'(error), 32'd0);
        check("glitch_wr",      32'(n_wr), 32'd0);

        // Two-word load follows the glitch without reset
        send_word(32'h0000_0002);
        check("two_loading", 32'(loading), 32'd1);
        send_word(32'h0010_0513);
        send_word(32'h00B5_05B3);
        repeat (4) @(negedge clk);
        check("two_nwr",   32'(n_wr), 32'd2);
        check("two_a0",    wr_addr[0], 32'h000);
        check("two_d0",    wr_data[0], 32'h0010_0513);
        check("two_a1",    wr_addr[1], 32'h004);
        check("two_d1",    wr_data[1], 32'h00B5_05B3);
        check("two_cpu",   32'(cpu_reset_n), 32'd1);
        check("two_error", 32'(error), 32'd0);
        check("two_loading_done", 32'(loading), 32'd0);
        check("two_cpu_at_wr", 32'(n_cpu_hi_at_wr), 32'd0);
        check("two_hold_addr", 32'(rom_if.rom_write_address), 32'h004);
        check("two_hold_data", rom_if.rom_write_data, 32'h00B5_05B3);
        send_word(32'h1234_5678);
        repeat (4) @(negedge clk);
        check("run_ignore_nwr", 32'(n_wr), 32'd2);
        check("run_cpu", 32'(cpu_reset_n), 32'd1);

        // Zero-length program
        do_reset();
        check("rst_cpu_after_run", 32'(cpu_reset_n), 32'd0);
        send_word(32'h0000_0000);
        check("zero_cpu",  32'(cpu_reset_n), 32'd1);
        check("zero_nwr",  32'(n_wr), 32'd0);
        check("zero_error", 32'(error), 32'd0);

        // Oversized program (1025 words)
        do_reset();
        send_word(32'h0000_0401);
        check("big_error", 32'(error), 32'd1);
        check("big_cpu",   32'(cpu_reset_n), 32'd0);
        send_word(32'hAABB_CCDD);
        check("big_error_sticky", 32'(error), 32'd1);
        check("big_nwr",   32'(n_wr), 32'd0);
        check("big_loading", 32'(loading), 32'd0);

        // Frame error in the second word, then recovery
        do_reset();
        send_word(32'h0000_0002);
        send_word(32'h4433_2211);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b1);
        repeat (4) @(negedge clk);
        check("ferr_nwr",   32'(n_wr), 32'd1);
        check("ferr_a0",    wr_addr[0], 32'h000);
        check("ferr_d0",    wr_data[0], 32'h4433_2211);
        check("ferr_error", 32'(error), 32'd1);
        check("ferr_cpu",   32'(cpu_reset_n), 32'd0);
        do_reset();
        check("ferr_rst_error", 32'(error), 32'd0);
        send_word(32'h0000_0001);
        send_word(32'hDDCC_BBAA);
        repeat (4) @(negedge clk);
        check("recov_nwr",   32'(n_wr), 32'd1);
        check("recov_a0",    wr_addr[0], 32'h000);
        check("recov_d0",    wr_data[0], 32'hDDCC_BBAA);
        check("recov_error", 32'(error), 32'd0);
        check("recov_cpu",   32'(cpu_reset_n), 32'd1);

        // Reset mid-word discards the partial data
        do_reset();
        send_word(32'h0000_0001);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        do_reset();
        send_word(32'h0000_0001);
        send_word(32'hDEAD_BEEF);
        repeat (4) @(negedge clk);
        check("midrst_nwr", 32'(n_wr), 32'd1);
        check("midrst_a0",  wr_addr[0], 32'h000);
        check("midrst_d0",  wr_data[0], 32'hDEAD_BEEF);
        check("midrst_cpu", 32'(cpu_reset_n), 32'd1);

        check("no_back_to_back_wren", 32'(n_consec), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
